// File: rtl/hc595_pkg.sv
// Shared types for the 74HC595 chain driver: FSM state and shift-clock phase.
package hc595_pkg;

    // Frame sequencing: wait for a word, clock it out, latch it into the 595 outputs.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Half of one shcp period; ds is set up during LOW and sampled by the 595 on the LOW->HIGH edge.
    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    localparam int STATE_W = 2;

endpackage

// File: rtl/hc595_tick_gen.sv
// Divider producing a one-cycle tick every DIV system clocks while the driver is busy.
// The count is forced to zero on frame accept so every frame starts on a clean phase.
module hc595_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running modulo-DIV count while running; parked at zero when idle or restarting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = run && !restart && (cnt == LAST);

endmodule

// File: rtl/hc595_chain_driver.sv
// Serial driver for a cascade of 74HC595 registers. A word accepted through the
// valid/ready handshake is clocked out on ds/shcp (one bit per 2*DIV cycles), then
// stcp is held high for DIV cycles to latch it. All pin outputs are registered.
//
// Handshake: a frame is transferred on a rising edge where data_valid and
// data_ready are both high; data_ready is high only while idle, data_in is
// sampled only on that edge, and data_valid without data_ready is ignored.
module hc595_chain_driver
    import hc595_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              oe_en,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe,
    output logic              busy,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t             state;
    phase_t             phase;
    logic [DATA_W-1:0]  sreg;
    logic [DATA_W-1:0]  sreg_adv;
    logic [BIT_W-1:0]   bit_cnt;
    logic               accept;
    logic               tick;
    logic               first_bit;
    logic               next_bit;
    logic               last_bit;

    assign accept    = data_valid && data_ready;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign dbg_state = state;

    hc595_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .restart(accept),
        .run    (busy),
        .tick   (tick)
    );

    // Bit selection for the configured order: the outgoing bit always sits at one end of sreg.
    always_comb begin
        sreg_adv  = '0;
        first_bit = 1'b0;
        next_bit  = 1'b0;
        if (MSB_FIRST != 0) begin
            sreg_adv  = sreg << 1;
            first_bit = data_in[DATA_W-1];
            next_bit  = sreg_adv[DATA_W-1];
        end else begin
            sreg_adv  = sreg >> 1;
            first_bit = data_in[0];
            next_bit  = sreg_adv[0];
        end
    end

    // Frame FSM with registered pin outputs; phases only advance on the divider tick.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            phase      <= PH_LOW;
            sreg       <= '0;
            bit_cnt    <= '0;
            ds         <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            data_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sreg       <= data_in;
                        bit_cnt    <= '0;
                        phase      <= PH_LOW;
                        ds         <= first_bit;
                        shcp       <= 1'b0;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (phase == PH_LOW) begin
                            // ds has been stable for DIV cycles; raise the shift clock.
                            phase <= PH_HIGH;
                            shcp  <= 1'b1;
                        end else begin
                            phase   <= PH_LOW;
                            shcp    <= 1'b0;
                            sreg    <= sreg_adv;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (last_bit) begin
                                ds    <= 1'b0;
                                stcp  <= 1'b1;
                                state <= ST_LATCH;
                            end else begin
                                ds <= next_bit;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        stcp       <= 1'b0;
                        data_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    phase      <= PH_LOW;
                    ds         <= 1'b0;
                    shcp       <= 1'b0;
                    stcp       <= 1'b0;
                    data_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Active-low output enable, registered so it lags oe_en by one cycle in every state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            oe <= 1'b1;
        end else begin
            oe <= ~oe_en;
        end
    end

endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Parametrised serial driver for a cascade of 74HC595 shift registers. Accepts a parallel word via valid/ready handshake and shifts it out on `ds`/`shcp`, then pulses `stcp` to latch it. Supports configurable chain width, shift-clock rate and bit order. It sits between display/pattern generators (e.g. segment/select encoders) and the board's 595 pins, and replaces the fixed-width static driver.

## Interface
- `DATA_W`, 14, total bits shifted per frame (6 select + 8 segment for the standard 6-digit board); ≥1
- `DIV`, 2, sys_clk cycles per shcp half-period; ≥1
- `MSB_FIRST`, 1, 1: `data_in[DATA_W-1]` shifted first; 0: `data_in[0]` first
- `sys_clk`  in  1  system clock; all logic on rising edge
- `sys_rst`  in  1  asynchronous, active-high reset
- `data_in`  in  DATA_W  frame to transmit; sampled only on handshake
- `data_valid`  in  1  frame request
- `data_ready`  out  1  high only in IDLE
- `oe_en`  in  1  1 = enable 595 outputs
- `ds`  out  1  serial data to first 595
- `shcp`  out  1  shift clock
- `stcp`  out  1  storage (latch) clock
- `oe`  out  1  active-low output enable = registered `~oe_en`
- `busy`  out  1  high in SHIFT and LATCH

## Operation
- Reset values: `ds`=0, `shcp`=0, `stcp`=0, `oe`=1 (outputs disabled), `data_ready`=1, `busy`=0, state IDLE, counters 0.
- States: IDLE → SHIFT → LATCH → IDLE.
- IDLE: `data_ready`=1. `data_valid & data_ready` captures `data_in` into shift register, clears bit and divider counters, → SHIFT. `data_valid` without ready is ignored; `data_in` changes after capture do not affect the frame in flight.
- SHIFT: per bit, phase LOW (`shcp`=0, `ds`=current bit) for DIV cycles, then phase HIGH (`shcp`=1, `ds` held) for DIV cycles. On leaving HIGH: shift register advances by one (direction per MSB_FIRST), bit counter increments. After bit DATA_W-1 HIGH phase → LATCH with `shcp`=0.
- LATCH: `stcp`=1 for DIV cycles, `ds`=0; then `stcp`=0, → IDLE.
- Bit counter width `$clog2(DATA_W+1)`; divider counter width `$clog2(DIV+1)`; no wrap occurs inside a frame.
- `oe` updates every cycle from `oe_en`, independent of state (blanking allowed mid-frame).
- Reset mid-frame: immediate return to reset values; `stcp` never pulses, so 595 outputs keep last latched frame.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Handshake accepted at edge T: `data_ready`=0, `busy`=1, `ds`=first bit from T+1.
- Bit k (0-based): `shcp` rises at T+1+DIV+2·DIV·k, falls at T+1+2·DIV·(k+1). `ds` stable ≥DIV cycles before and after each rising edge.
- `stcp` high for cycles T+1+2·DIV·DATA_W … T+2·DIV·DATA_W+DIV.
- `data_ready`=1 again at T+1+2·DIV·DATA_W+DIV; back-to-back frame accepted that same cycle if `data_valid`=1 → frame period 2·DIV·DATA_W+DIV+1 cycles (59 for defaults).
- `oe` lags `oe_en` by exactly 1 cycle.

## Structure
- Package `hc595_pkg`: state enum (IDLE, SHIFT, LATCH), phase encoding (LOW/HIGH).
- Sub-module `hc595_tick_gen`: DIV-cycle divider producing a one-cycle `tick` enable, restarted on frame accept; FSM advances phases only on `tick`.
- No other hierarchy; top wiring of encoder + driver lives in the board-level module.

## Test plan
- Reset: assert `sys_rst` mid-SHIFT → next cycle `ds`=0, `shcp`=0, `stcp`=0, `oe`=1, `data_ready`=1; no `stcp` pulse seen.
- Single frame, defaults, `data_in`=14'h2A5C: bench model of 595 chain samples `ds` on `shcp` rise, latches on `stcp` rise → captures 14'h2A5C; exactly 14 `shcp` rises, one `stcp` pulse of 2 cycles.
- MSB_FIRST=0, DATA_W=8, DIV=1, `data_in`=8'h01 → first `ds` bit 1, remaining 7 bits 0; frame period 8·2+1+1=18 cycles.
- Back-to-back: `data_valid` held high with 14'h3FFF then 14'h0000 → second accepted exactly 59 cycles after first; model shows 3FFF then 0000.
- Handshake: `data_valid` pulsed during SHIFT, `data_in` changed mid-frame → ignored, in-flight frame unchanged.
- `oe_en` toggled 0→1→0 during SHIFT → `oe` follows inverted with 1-cycle lag; shift sequence undisturbed.
